washer_panel_ctrl: RTL

Front-panel controller that sits directly upstream of the washing machine FSM. It debounces the raw start and pause push-buttons and tracks the door sensor. It latches the double-wash and dry-wash selector switches at cycle start, then drives the machine's `start`, `double_wash`, `dry_wash` and `time_pause` inputs. It consumes the machine's `done` output to close the cycle and release the door lock.

---
 rtl/washer_panel_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/washer_panel_ctrl.sv
// rtl/washer_panel_ctrl.sv - front-panel button/door controller feeding the washing machine FSM
module washer_panel_ctrl #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_pause,
    input  logic sw_double,
    input  logic sw_dry,
    input  logic door_closed,
    input  logic done,
    output logic start,
    output logic double_wash,
    output logic dry_wash,
    output logic time_pause,
    output logic door_lock,
    output logic door_err
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_PAUSED
    } state_t;

    // bit 0 = start button, bit 1 = pause button, bit 2 = door sensor
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;

    // bit 0 = start button, bit 1 = pause button
    logic [1:0]    r_deb;
    logic [1:0]    r_deb_d;
    logic [1:0]    r_press;
    logic [CW-1:0] r_cnt [2];

    state_t        r_state;
    state_t        w_state_nx;
    logic          w_dbl_nx;
    logic          w_dry_nx;
    logic          w_err_nx;
    logic          w_door_ok;
    logic          w_ev_start;
    logic          w_ev_pause;

    assign w_door_ok  = r_sync2[2];
    assign w_ev_start = r_press[0];
    assign w_ev_pause = r_press[1];

    // two-flop synchronizers for the asynchronous buttons and door sensor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {door_closed, btn_pause, btn_start};
            r_sync2 <= r_sync1;
        end
    end

    // debounce counters; the debounced level flips on the DEBOUNCE-th consecutive differing sample,
    // and a press event is registered one cycle after the debounced level rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            r_press <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == C_LAST) begin
                    r_cnt[i] <= '0;
                    r_deb[i] <= ~r_deb[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + C_ONE;
                end
            end
        end
    end

    // next-state logic; done outranks pause/door in RUN and PAUSED, start outranks pause in IDLE
    always_comb begin
        w_state_nx = r_state;
        w_dbl_nx   = double_wash;
        w_dry_nx   = dry_wash;
        w_err_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ev_start) begin
                    if (w_door_ok) begin
                        w_dbl_nx   = sw_double;
                        w_dry_nx   = sw_dry;
                        w_state_nx = S_START;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            S_START: begin
                // a done still high from the previous cycle must drop before we count as running
                if (!done) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (done) begin
                    w_state_nx = S_IDLE;
                end else if (w_ev_pause || !w_door_ok) begin
                    w_state_nx = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (done) begin
                    w_state_nx = S_IDLE;
                end else if (w_ev_pause) begin
                    if (w_door_ok) begin
                        w_state_nx = S_RUN;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // state register with outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            start       <= 1'b0;
            door_lock   <= 1'b0;
            time_pause  <= 1'b0;
            double_wash <= 1'b0;
            dry_wash    <= 1'b0;
            door_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            start       <= (w_state_nx != S_IDLE);
            door_lock   <= (w_state_nx != S_IDLE);
            time_pause  <= (w_state_nx == S_PAUSED);
            double_wash <= w_dbl_nx;
            dry_wash    <= w_dry_nx;
            door_err    <= w_err_nx;
        end
    end

endmodule
